// File: rtl/game_pkg.sv
// Shared definitions for the rhythm game controller: state encodings seen by
// the LED decoder and display path, plus count widths.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_PLAY  = 3'b001,
    ST_STOP  = 3'b010,
    ST_SCORE = 3'b011,
    ST_SPEED = 3'b100,
    ST_MISS  = 3'b101
  } state_t;

  localparam int unsigned SCORE_W = 8;
  localparam int unsigned MISS_W  = 4;
  localparam int unsigned NOTE_W  = 8;
  localparam int unsigned SPEED_W = 2;

  localparam logic [SPEED_W-1:0] SPEED_MAX = '1;

  // Increment that sticks at all-ones.
  function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] v);
    return (v == '1) ? v : v + MISS_W'(1);
  endfunction

endpackage

// File: rtl/game_hit_window.sv
// Note hit window: loads HIT_WINDOW ticks, counts down on tick while running,
// holds its value while frozen. expire flags the tick that would reach zero,
// so a hit in that same cycle can still take priority.
module game_hit_window #(
  parameter int unsigned HIT_WINDOW = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic run,
  input  logic load,
  input  logic close,
  output logic open,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(HIT_WINDOW + 1);

  logic [CNT_W-1:0] cnt;

  assign open   = (cnt != '0);
  assign expire = run && tick && (cnt == CNT_W'(1));

  // Remaining-ticks counter; load beats close beats decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(HIT_WINDOW);
    end else if (close) begin
      cnt <= '0;
    end else if (run && tick && open) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_fsm.sv
// Central rhythm game controller: sequences idle/speed/play/stop/miss/score,
// judges notes against the hit window and keeps score, miss and note counts.
module game_fsm
  import game_pkg::*;
#(
  parameter int unsigned HIT_WINDOW = 100,
  parameter int unsigned MISS_HOLD  = 500,
  parameter int unsigned MISS_LIMIT = 3,
  parameter int unsigned SONG_LEN   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_hit,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       note_due,
  output logic [2:0] state,
  output logic [7:0] score,
  output logic [3:0] miss_cnt,
  output logic [1:0] speed_lvl,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  localparam int unsigned HOLD_W = $clog2(MISS_HOLD + 1);
  localparam logic [NOTE_W-1:0] SONG_END   = NOTE_W'(SONG_LEN);
  localparam logic [MISS_W-1:0] MISS_END   = MISS_W'(MISS_LIMIT);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(MISS_HOLD);

  state_t              state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [SPEED_W-1:0]  speed_q, speed_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                hit_p_d, miss_p_d;
  logic [NOTE_W-1:0]   note_inc;

  logic win_run, win_load, win_close, win_open, win_expire;

  game_hit_window #(
    .HIT_WINDOW (HIT_WINDOW)
  ) u_window (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .run    (win_run),
    .load   (win_load),
    .close  (win_close),
    .open   (win_open),
    .expire (win_expire)
  );

  assign note_inc  = note_q + NOTE_W'(1);
  assign state     = state_q;
  assign score     = score_q;
  assign miss_cnt  = miss_q;
  assign speed_lvl = speed_q;

  // Next-state, count updates and window controls.
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    miss_d    = miss_q;
    note_d    = note_q;
    speed_d   = speed_q;
    hold_d    = hold_q;
    hit_p_d   = 1'b0;
    miss_p_d  = 1'b0;
    win_run   = 1'b0;
    win_load  = 1'b0;
    win_close = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (btn_start) state_d = ST_SPEED;
      end

      ST_SPEED: begin
        if (btn_up && !btn_down && speed_q != SPEED_MAX) begin
          speed_d = speed_q + SPEED_W'(1);
        end else if (btn_down && !btn_up && speed_q != '0) begin
          speed_d = speed_q - SPEED_W'(1);
        end
        if (btn_start) begin
          state_d   = ST_PLAY;
          score_d   = '0;
          miss_d    = '0;
          note_d    = '0;
          win_close = 1'b1;
        end
      end

      ST_PLAY: begin
        win_run = 1'b1;
        // A hit outranks both expiry and an overrunning note_due; the
        // overrunning note then simply reopens the window.
        if (btn_hit && win_open) begin
          score_d = sat_inc_score(score_q);
          note_d  = note_inc;
          hit_p_d = 1'b1;
          if (note_due) win_load  = 1'b1;
          else          win_close = 1'b1;
          if (note_inc == SONG_END) state_d = ST_SCORE;
          else if (btn_pause)       state_d = ST_STOP;
        end else if (win_expire || (note_due && win_open)) begin
          miss_d    = sat_inc_miss(miss_q);
          note_d    = note_inc;
          miss_p_d  = 1'b1;
          win_close = 1'b1;
          hold_d    = HOLD_LOAD;
          state_d   = ST_MISS;
        end else begin
          if (note_due)  win_load = 1'b1;
          if (btn_pause) state_d  = ST_STOP;
        end
      end

      ST_STOP: begin
        if (btn_pause)      state_d = ST_PLAY;
        else if (btn_start) state_d = ST_IDLE;
      end

      ST_MISS: begin
        if (tick) begin
          if (hold_q <= HOLD_W'(1)) begin
            hold_d = '0;
            if (miss_q >= MISS_END || note_q == SONG_END) state_d = ST_SCORE;
            else                                           state_d = ST_PLAY;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end

      ST_SCORE: begin
        if (btn_start) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counts and judgement strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      miss_q     <= '0;
      note_q     <= '0;
      speed_q    <= '0;
      hold_q     <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      miss_q     <= miss_d;
      note_q     <= note_d;
      speed_q    <= speed_d;
      hold_q     <= hold_d;
      hit_pulse  <= hit_p_d;
      miss_pulse <= miss_p_d;
    end
  end

endmodule
